req_arbiter_4: RTL and testbench

//  Shares one downstream resource between N requesters with registered, one-hot grants.

---
 rtl/req_arbiter_4.sv | 145 ++++++++++++++
 tb/tb_req_arbiter_4.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_4.sv
// req_arbiter_4: shares one downstream resource between N requesters.
// Grants are registered and one-hot. Winner selection is highest-index-first,
// optionally rotated round-robin after each grant, with a hold limit that
// forces the owner to yield when other requesters are waiting.
module req_arbiter_4 #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           none,
  output logic           expired
);

  localparam int HCW_RAW = $clog2(MAX_HOLD + 1);
  localparam int HCW     = (HCW_RAW < 1) ? 1 : HCW_RAW;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state_q,    state_d;
  logic [N-1:0]   gnt_q,      gnt_d;
  logic [IDW-1:0] gnt_id_q,   gnt_id_d;
  logic           expired_q,  expired_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0] last_q,     last_d;

  logic [N-1:0]   others;
  logic           owner_req;
  logic [IDW-1:0] pick_all;
  logic [IDW-1:0] pick_oth;

  // Search order starts just below 'from' and wraps; with rotation disabled the
  // plain highest set index wins. Later loop iterations override earlier ones,
  // so the loop walks from lowest to highest priority.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] cand,
                                          input logic [IDW-1:0] from);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    win = '0;
    for (int k = N; k >= 1; k--) begin
      if (RR_EN != 0) idx = IDW'((int'(from) + N - k) % N);
      else            idx = IDW'(N - k);
      if (cand[idx]) win = idx;
    end
    return win;
  endfunction

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign expired   = expired_q;
  assign none      = ~|req;

  // Next-state logic: grant, hold, handover, preemption by hold limit, release.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    expired_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    others     = req & ~gnt_q;
    owner_req  = req[gnt_id_q];
    pick_all   = pick(req, last_q);
    pick_oth   = pick(others, last_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d           = BUSY;
          gnt_d             = '0;
          gnt_d[pick_all]   = 1'b1;
          gnt_id_d          = pick_all;
          last_d            = pick_all;
          hold_cnt_d        = '0;
        end
      end
      BUSY: begin
        if (owner_req) begin
          if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
            if (|others) begin
              gnt_d           = '0;
              gnt_d[pick_oth] = 1'b1;
              gnt_id_d        = pick_oth;
              last_d          = pick_oth;
              hold_cnt_d      = '0;
              expired_d       = 1'b1;
            end else begin
              hold_cnt_d = '0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end else if (|req) begin
          gnt_d           = '0;
          gnt_d[pick_all] = 1'b1;
          gnt_id_d        = pick_all;
          last_d          = pick_all;
          hold_cnt_d      = '0;
        end else begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        gnt_id_d   = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      expired_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      expired_q  <= expired_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_req_arbiter_4.sv
// Testbench for req_arbiter_4: two instances (round-robin with hold limit 8,
// and fixed priority without limit) driven by the same request vector.
module tb_req_arbiter_4;

  typedef struct {
    int owner;
    int last;
    int hold;
    bit exp;
  } mstate_t;

  typedef struct {
    bit         rst;
    bit         sel;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt_rr, gnt_fp;
  logic [1:0] id_rr, id_fp;
  logic       val_rr, val_fp;
  logic       none_rr, none_fp;
  logic       exp_rr, exp_fp;

  int checks;
  int failures;

  mstate_t m_rr, m_fp;
  vec_t    vecs[$];

  req_arbiter_4 #(.N(4), .IDW(2), .RR_EN(1), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_rr), .gnt_id(id_rr),
    .gnt_valid(val_rr), .none(none_rr), .expired(exp_rr)
  );

  req_arbiter_4 #(.N(4), .IDW(2), .RR_EN(0), .MAX_HOLD(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_fp), .gnt_id(id_fp),
    .gnt_valid(val_fp), .none(none_fp), .expired(exp_fp)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic mstate_t idle_state();
    mstate_t s;
    s.owner = -1;
    s.last  = 0;
    s.hold  = 0;
    s.exp   = 1'b0;
    return s;
  endfunction

  // First requester found walking the search order, -1 when none is set.
  function automatic int pick(input logic [3:0] cand, input int last, input bit rr);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = rr ? (last - k + 4) % 4 : 4 - k;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [3:0] r,
                                         input bit rr, input int mh);
    mstate_t    n;
    logic [3:0] oth;
    n     = s;
    n.exp = 1'b0;
    if (s.owner < 0) begin
      if (r != 4'b0) begin
        n.owner = pick(r, s.last, rr);
        n.last  = n.owner;
        n.hold  = 0;
      end
    end else if (r[s.owner]) begin
      if (mh != 0 && s.hold == mh - 1) begin
        oth = r;
        oth[s.owner] = 1'b0;
        if (oth != 4'b0) begin
          n.owner = pick(oth, s.last, rr);
          n.last  = n.owner;
          n.exp   = 1'b1;
        end
        n.hold = 0;
      end else begin
        n.hold = s.hold + 1;
      end
    end else if (r != 4'b0) begin
      n.owner = pick(r, s.last, rr);
      n.last  = n.owner;
      n.hold  = 0;
    end else begin
      n.owner = -1;
      n.hold  = 0;
    end
    return n;
  endfunction

  function automatic logic [3:0] model_gnt(input mstate_t s);
    return (s.owner < 0) ? 4'b0000 : (4'b0001 << s.owner);
  endfunction

  function automatic logic [1:0] model_id(input mstate_t s);
    return (s.owner < 0) ? 2'd0 : 2'(s.owner);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare both instances against their reference models.
  task automatic checkOutput();
    checkVal("rr_gnt",   32'(gnt_rr),  32'(model_gnt(m_rr)));
    checkVal("rr_id",    32'(id_rr),   32'(model_id(m_rr)));
    checkVal("rr_valid", 32'(val_rr),  32'(m_rr.owner >= 0));
    checkVal("rr_exp",   32'(exp_rr),  32'(m_rr.exp));
    checkVal("rr_none",  32'(none_rr), 32'(req == 4'b0));
    checkVal("fp_gnt",   32'(gnt_fp),  32'(model_gnt(m_fp)));
    checkVal("fp_id",    32'(id_fp),   32'(model_id(m_fp)));
    checkVal("fp_valid", 32'(val_fp),  32'(m_fp.owner >= 0));
    checkVal("fp_exp",   32'(exp_fp),  32'(m_fp.exp));
    checkVal("fp_none",  32'(none_fp), 32'(req == 4'b0));
  endtask

  // Drive one request vector across one rising edge, then check.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    m_rr = model_next(m_rr, r, 1'b1, 8);
    m_fp = model_next(m_fp, r, 1'b0, 0);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    checkVal("async_rr_gnt", 32'(gnt_rr), 32'h0);
    checkVal("async_fp_gnt", 32'(gnt_fp), 32'h0);
    checkVal("async_rr_exp", 32'(exp_rr), 32'h0);
    m_rr = idle_state();
    m_fp = idle_state();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input bit rst, input bit sel, input logic [3:0] r,
                         input logic [3:0] g, input logic e);
    vec_t v;
    v.rst = rst;
    v.sel = sel;
    v.req = r;
    v.gnt = g;
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] r;
    checks   = 0;
    failures = 0;
    m_rr     = idle_state();
    m_fp     = idle_state();

    rst_n = 1'b0;
    req   = 4'b1111;
    #3;
    checkVal("rst_gnt",   32'(gnt_rr),  32'h0);
    checkVal("rst_id",    32'(id_rr),   32'h0);
    checkVal("rst_valid", 32'(val_rr),  32'h0);
    checkVal("rst_exp",   32'(exp_rr),  32'h0);
    checkVal("rst_none",  32'(none_rr), 32'h0);
    @(posedge clk);
    #1;
    checkVal("rst_hold_gnt", 32'(gnt_rr), 32'h0);
    checkVal("rst_hold_fp",  32'(gnt_fp), 32'h0);
    rst_n = 1'b1;

    applyStimulus(4'b0100);
    checkVal("first_grant", 32'(gnt_rr), 32'h4);
    applyStimulus(4'b0100);
    apply_reset();
    req = 4'b0000;
    #1;
    checkVal("none_comb_hi", 32'(none_rr), 32'h1);
    req = 4'b0010;
    #1;
    checkVal("none_comb_lo", 32'(none_fp), 32'h0);
    req = 4'b0000;

    // Fixed priority on the unlimited instance.
    add_vec(0, 1, 4'b0110, 4'b0100, 0);
    add_vec(0, 1, 4'b0110, 4'b0100, 0);
    add_vec(0, 1, 4'b0010, 4'b0010, 0);
    add_vec(0, 1, 4'b0000, 4'b0000, 0);
    // Round-robin rotation with one-cycle drops.
    add_vec(1, 0, 4'b1111, 4'b1000, 0);
    add_vec(0, 0, 4'b0111, 4'b0100, 0);
    add_vec(0, 0, 4'b1011, 4'b0010, 0);
    add_vec(0, 0, 4'b1101, 4'b0001, 0);
    add_vec(0, 0, 4'b1110, 4'b1000, 0);
    // Hold limit preemption in both directions.
    for (int i = 0; i < 8; i++) add_vec(i == 0, 0, 4'b1001, 4'b1000, 0);
    add_vec(0, 0, 4'b1001, 4'b0001, 1);
    for (int i = 0; i < 7; i++) add_vec(0, 0, 4'b1001, 4'b0001, 0);
    add_vec(0, 0, 4'b1001, 4'b1000, 1);
    add_vec(0, 0, 4'b1001, 4'b1000, 0);
    // Lone owner never expires.
    for (int i = 0; i < 20; i++) add_vec(i == 0, 0, 4'b0010, 4'b0010, 0);
    // Release and new request on the limit cycle.
    for (int i = 0; i < 8; i++) add_vec(i == 0, 0, 4'b1000, 4'b1000, 0);
    add_vec(0, 0, 4'b0001, 4'b0001, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      applyStimulus(vecs[i].req);
      if (vecs[i].sel) begin
        checkVal($sformatf("vec%0d_fp_gnt", i), 32'(gnt_fp), 32'(vecs[i].gnt));
        checkVal($sformatf("vec%0d_fp_exp", i), 32'(exp_fp), 32'(vecs[i].exp));
      end else begin
        checkVal($sformatf("vec%0d_rr_gnt", i), 32'(gnt_rr), 32'(vecs[i].gnt));
        checkVal($sformatf("vec%0d_rr_exp", i), 32'(exp_rr), 32'(vecs[i].exp));
      end
    end

    // Sticky random requests so that long holds and preemptions occur.
    apply_reset();
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 149) == 0) apply_reset();
      applyStimulus(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
